// File: rtl/i2s_rx.sv
// ============================================================================
// Module   : i2s_rx
// Function : Oversampling slave I2S receiver, delivers L/R tagged words on a
//            valid/ready stream in the adc_clk domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_rx #(
  parameter int SAMPLE_SIZE = 24,
  parameter int BIT_CNT_W   = 5
) (
  input  logic                   adc_clk,
  input  logic                   adc_rst_n,
  input  logic                   rx_en,
  input  logic                   i2s_bclk,
  input  logic                   i2s_wclk,
  input  logic                   i2s_sdata,
  output logic [SAMPLE_SIZE-1:0] sample_data,
  output logic                   sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   err_clr
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [BIT_CNT_W:0]   c_word_len = (BIT_CNT_W+1)'(SAMPLE_SIZE);
  localparam logic [BIT_CNT_W:0]   c_len_one  = (BIT_CNT_W+1)'(1);
  localparam logic [BIT_CNT_W-1:0] c_cnt_one  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] c_cnt_max  = '1;

  state_t r_state;
  state_t w_state_nxt;

  logic r_bclk_s1, r_bclk_s2, r_bclk_h;
  logic r_wclk_s1, r_wclk_s2, r_wclk_h;
  logic r_sdata_s1, r_sdata_s2, r_sdata_h;

  logic [SAMPLE_SIZE-1:0] r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_wc_prev;
  logic                   r_good;
  logic                   r_good_right;

  logic [SAMPLE_SIZE-1:0] r_data;
  logic                   r_right;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_frame_err;

  logic                 w_rise;
  logic                 w_wc_chg;
  logic [BIT_CNT_W:0]   w_cnt_p1;
  logic                 w_len_ok;
  logic                 w_word_good;
  logic                 w_word_bad;
  logic                 w_take;
  logic                 w_ovf_evt;

  // wclk/sdata are taken from their history flops so all three lines share
  // the same synchroniser depth at the moment a bclk rise is seen.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_bclk_s1  <= 1'b0;
      r_bclk_s2  <= 1'b0;
      r_bclk_h   <= 1'b0;
      r_wclk_s1  <= 1'b0;
      r_wclk_s2  <= 1'b0;
      r_wclk_h   <= 1'b0;
      r_sdata_s1 <= 1'b0;
      r_sdata_s2 <= 1'b0;
      r_sdata_h  <= 1'b0;
    end else begin
      r_bclk_s1  <= i2s_bclk;
      r_bclk_s2  <= r_bclk_s1;
      r_bclk_h   <= r_bclk_s2;
      r_wclk_s1  <= i2s_wclk;
      r_wclk_s2  <= r_wclk_s1;
      r_wclk_h   <= r_wclk_s2;
      r_sdata_s1 <= i2s_sdata;
      r_sdata_s2 <= r_sdata_s1;
      r_sdata_h  <= r_sdata_s2;
    end
  end

  always_comb begin
    w_rise      = r_bclk_s2 & ~r_bclk_h;
    w_wc_chg    = w_rise & (r_wclk_h != r_wc_prev);
    w_cnt_p1    = {1'b0, r_bit_cnt} + c_len_one;
    w_len_ok    = (w_cnt_p1 == c_word_len);
    w_word_good = rx_en & (r_state == ST_RUN) & w_wc_chg & w_len_ok;
    w_word_bad  = rx_en & (r_state == ST_RUN) & w_wc_chg & ~w_len_ok;
    w_state_nxt = r_state;
    if (!rx_en) begin
      w_state_nxt = ST_HUNT;
    end else if ((r_state == ST_HUNT) && w_wc_chg) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_shift      <= '0;
      r_wc_prev    <= 1'b0;
      r_bit_cnt    <= '0;
      r_good       <= 1'b0;
      r_good_right <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_rise) begin
        r_shift   <= {r_shift[SAMPLE_SIZE-2:0], r_sdata_h};
        r_wc_prev <= r_wclk_h;
      end
      if (!rx_en) begin
        r_bit_cnt <= '0;
      end else if (w_wc_chg) begin
        r_bit_cnt <= '0;
      end else if (w_rise && (r_bit_cnt != c_cnt_max)) begin
        r_bit_cnt <= r_bit_cnt + c_cnt_one;
      end
      r_good       <= w_word_good;
      r_good_right <= r_wc_prev;
      r_frame_err  <= (r_frame_err & ~err_clr) | w_word_bad;
    end
  end

  // A new word may replace the held one only when that one is leaving now.
  assign w_take    = r_good & (~r_valid | sample_ready);
  assign w_ovf_evt = r_good & r_valid & ~sample_ready;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_data     <= '0;
      r_right    <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_take) begin
        r_data  <= r_shift;
        r_right <= r_good_right;
        r_valid <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
      r_overflow <= (r_overflow & ~err_clr) | w_ovf_evt;
    end
  end

  assign sample_data  = r_data;
  assign sample_right = r_right;
  assign sample_valid = r_valid;
  assign overflow     = r_overflow;
  assign frame_err    = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx.sv
// ============================================================================
// Module   : tb_i2s_rx
// Function : Self-checking bench for i2s_rx against a slot-level I2S model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_rx;

  localparam int c_ss = 24;

  typedef struct packed {
    logic            right;
    logic [c_ss-1:0] data;
  } word_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rx_en;
  logic            bclk;
  logic            wclk;
  logic            sdata;
  logic [c_ss-1:0] sample_data;
  logic            sample_right;
  logic            sample_valid;
  logic            sample_ready;
  logic            overflow;
  logic            frame_err;
  logic            err_clr;

  int n_chk  = 0;
  int n_fail = 0;
  int half;

  word_t           m_q[$];
  logic            m_hunt     = 1'b1;
  logic            m_en       = 1'b1;
  logic            m_frame    = 1'b0;
  logic            m_ovf      = 1'b0;
  logic            m_hs_next  = 1'b0;
  logic            m_prev_ch  = 1'b0;
  logic            m_next_ch  = 1'b0;
  int              m_prev_len = 0;
  logic [c_ss-1:0] m_prev_word = '0;

  event ev_rise;

  i2s_rx #(.SAMPLE_SIZE(c_ss), .BIT_CNT_W(5)) u_dut (
    .adc_clk      (clk),
    .adc_rst_n    (rst_n),
    .rx_en        (rx_en),
    .i2s_bclk     (bclk),
    .i2s_wclk     (wclk),
    .i2s_sdata    (sdata),
    .sample_data  (sample_data),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted word must match the oldest word the model has queued.
  always @(negedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      if (m_q.size() == 0) begin
        chk("unexpected_word", {8'h0, sample_data}, 32'hDEAD);
      end else begin
        chk("word_data", {8'h0, sample_data}, {8'h0, m_q[0].data});
        chk("word_right", {31'h0, sample_right}, {31'h0, m_q[0].right});
        void'(m_q.pop_front());
      end
    end
  end

  // Slot-level rule: a slot ends when the next slot of the other channel
  // begins; only enabled, locked, full-length slots yield words.
  task automatic model_boundary(input logic ch);
    if (ch != m_prev_ch && m_en) begin
      if (m_hunt) begin
        m_hunt = 1'b0;
      end else if (m_prev_len != c_ss) begin
        m_frame = 1'b1;
      end else if (sample_ready || m_q.size() == 0 || m_hs_next) begin
        m_q.push_back({m_prev_ch, m_prev_word});
      end else begin
        m_ovf = 1'b1;
      end
      m_hs_next = 1'b0;
    end
  endtask

  task automatic send_bit(input logic wc, input logic sd);
    @(posedge clk); #2;
    bclk = 1'b0; wclk = wc; sdata = sd;
    repeat (half) @(posedge clk);
    #2; bclk = 1'b1; ->ev_rise;
    repeat (half - 1) @(posedge clk);
  endtask

  task automatic do_action(input int act);
    @(posedge clk); #2;
    if (act == 1) begin
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'h0, sample_valid}, 32'h0);
      chk("rst_data", {8'h0, sample_data}, 32'h0);
      chk("rst_right", {31'h0, sample_right}, 32'h0);
      chk("rst_ovf", {31'h0, overflow}, 32'h0);
      chk("rst_ferr", {31'h0, frame_err}, 32'h0);
      m_q.delete();
      m_hunt = 1'b1; m_frame = 1'b0; m_ovf = 1'b0; m_hs_next = 1'b0;
      repeat (2) @(posedge clk);
      #2; rst_n = 1'b1;
    end else if (act == 2) begin
      rx_en = 1'b0; m_en = 1'b0;
    end else if (act == 3) begin
      rx_en = 1'b1; m_en = 1'b1; m_hunt = 1'b1;
    end
  endtask

  // First bit of a slot carries the LSB of the previous word, then MSB first.
  task automatic send_slot(input logic [c_ss-1:0] word, input int len, input int act_at, input int act);
    logic ch;
    ch = m_next_ch;
    for (int k = 0; k < len; k++) begin
      if (k == act_at) do_action(act);
      if (k == 0) model_boundary(ch);
      send_bit(ch, (k == 0) ? m_prev_word[0] : word[c_ss-k]);
    end
    m_prev_word = word;
    m_prev_len  = len;
    m_prev_ch   = ch;
    m_next_ch   = ~ch;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #2;
    sample_ready = v;
  endtask

  task automatic clr_errs();
    @(posedge clk); #2; err_clr = 1'b1;
    @(posedge clk); #2; err_clr = 1'b0;
    m_frame = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    chk("clr_ferr", {31'h0, frame_err}, {31'h0, m_frame});
    chk("clr_ovf", {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b1; bclk = 1'b0; wclk = 1'b0; sdata = 1'b0;
    sample_ready = 1'b1; err_clr = 1'b0; half = 128;
    repeat (3) @(posedge clk);
    #1;
    chk("init_valid", {31'h0, sample_valid}, 32'h0);
    chk("init_data", {8'h0, sample_data}, 32'h0);
    chk("init_right", {31'h0, sample_right}, 32'h0);
    chk("init_ovf", {31'h0, overflow}, 32'h0);
    chk("init_ferr", {31'h0, frame_err}, 32'h0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Generator-rate stream with fixed words, then a fast random stream.
    send_slot(24'hA5C3F1, c_ss, -1, 0);
    send_slot(24'h123456, c_ss, -1, 0);
    send_slot(24'hA5C3F1, c_ss, -1, 0);
    send_slot(24'h123456, c_ss, -1, 0);
    half = 4;
    for (int i = 0; i < 16; i++) send_slot(24'($urandom), c_ss, -1, 0);
    chk("basic_ferr", {31'h0, frame_err}, {31'h0, m_frame});
    chk("basic_ovf", {31'h0, overflow}, {31'h0, m_ovf});

    // Short slot.
    send_slot(24'($urandom), c_ss - 1, -1, 0);
    send_slot(24'($urandom), c_ss, -1, 0);
    send_slot(24'($urandom), c_ss, -1, 0);
    chk("short_ferr", {31'h0, frame_err}, {31'h0, m_frame});
    chk("short_no_ovf", {31'h0, overflow}, {31'h0, m_ovf});
    clr_errs();

    // Back-pressure across two words.
    set_ready(1'b0);
    send_slot(24'($urandom), c_ss, -1, 0);
    send_slot(24'($urandom), c_ss, -1, 0);
    chk("hold_valid", {31'h0, sample_valid}, 32'h1);
    chk("hold_data", {8'h0, sample_data}, {8'h0, m_q[0].data});
    chk("hold_ovf", {31'h0, overflow}, {31'h0, m_ovf});
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    chk("release_valid", {31'h0, sample_valid}, 32'h0);
    chk("release_q", 32'(m_q.size()), 32'h0);
    clr_errs();

    // Ready lands on the very edge that loads the next word.
    send_slot(24'($urandom), c_ss, -1, 0);
    m_hs_next = 1'b1;
    fork
      begin
        @(ev_rise);
        repeat (3) @(posedge clk);
        #2; sample_ready = 1'b1;
        @(posedge clk);
        #2; sample_ready = 1'b0;
        @(negedge clk);
        chk("hs_valid", {31'h0, sample_valid}, 32'h1);
        chk("hs_data", {8'h0, sample_data}, {8'h0, m_q[0].data});
      end
    join_none
    send_slot(24'($urandom), c_ss, -1, 0);
    chk("hs_ovf", {31'h0, overflow}, {31'h0, m_ovf});
    set_ready(1'b1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a left slot while a word is held.
    set_ready(1'b0);
    send_slot(24'($urandom), c_ss, -1, 0);
    send_slot(24'($urandom), c_ss, 10, 1);
    set_ready(1'b1);
    for (int i = 0; i < 3; i++) send_slot(24'($urandom), c_ss, -1, 0);

    // Receiver disabled for three slots.
    send_slot(24'($urandom), c_ss, 10, 2);
    for (int i = 0; i < 3; i++) send_slot(24'($urandom), c_ss, -1, 0);
    send_slot(24'($urandom), c_ss, 10, 3);
    for (int i = 0; i < 4; i++) send_slot(24'($urandom), c_ss, -1, 0);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("end_q_empty", 32'(m_q.size()), 32'h0);
    chk("end_ferr", {31'h0, frame_err}, {31'h0, m_frame});
    chk("end_ovf", {31'h0, overflow}, {31'h0, m_ovf});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
